jtag_master: RTL

JTAG_MASTER -- requirements
Module: jtag_master

---
 rtl/jtag_master.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/jtag_master.sv
// jtag_master: Wishbone slave that shifts up to 32 TMS/TDI bits into a TAP,
// clocking TCK at a programmable rate and capturing TDO into a read-back register.
// Ports:
//   wb_clk_i, wb_rst_i      system clock, synchronous active-high reset
//   wb_cyc_i ... wb_adr_i   Wishbone slave request
//   wb_ack_o ... wb_data_o  Wishbone slave response
//   jtag_tck/tms/tdi/tdo    TAP pins
//   irq                     transfer-done interrupt, present only with JTAG_MASTER_IRQ_EN
// Registers (wb_adr_i[4:2]): 0 CONTROL, 1 DIVIDER, 2 TMS, 3 TDI, 4 TDO (read-only).
module jtag_master #(
    parameter int DIVIDER_WIDTH = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_data_i,
    input  logic [23:0] wb_adr_i,
    output logic        wb_ack_o,
    output logic        wb_stall_o,
    output logic        wb_error_o,
    output logic [31:0] wb_data_o,
    output logic        jtag_tck,
    output logic        jtag_tms,
    output logic        jtag_tdi,
    input  logic        jtag_tdo
`ifdef JTAG_MASTER_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH
    } state_t;

    localparam logic [2:0] A_CTRL = 3'd0;
    localparam logic [2:0] A_DIV  = 3'd1;
    localparam logic [2:0] A_TMS  = 3'd2;
    localparam logic [2:0] A_TDI  = 3'd3;
    localparam logic [2:0] A_TDO  = 3'd4;

    state_t r_state;
    state_t w_next_state;

    logic [DIVIDER_WIDTH-1:0] r_divider;
    logic [DIVIDER_WIDTH-1:0] r_phase_cnt;
    logic [5:0]  r_count;
    logic [5:0]  r_bit_idx;
    logic [31:0] r_tms;
    logic [31:0] r_tdi;
    logic [31:0] r_tdo;
    logic        r_tck;
    logic        r_tms_o;
    logic        r_tdi_o;
    logic        r_ack;
    logic        r_err;
    logic        r_stall;
    logic [31:0] r_data_o;

    logic        w_req;
    logic [2:0]  w_reg;
    logic        w_busy;
    logic        w_cnt_ok;
    logic        w_err;
    logic        w_wr_ok;
    logic        w_start;
    logic [31:0] w_mask;
    logic [31:0] w_div_wr;
    logic [31:0] w_tms_wr;
    logic [31:0] w_tdi_wr;
    logic [31:0] w_rdata;
    logic        w_irq_bit;
    logic        w_phase_done;
    logic        w_last_bit;
    logic [5:0]  w_next_idx;
    logic        w_unused_ok;

`ifdef JTAG_MASTER_IRQ_EN
    logic r_irq_en;
    logic r_irq;
    assign w_irq_bit = r_irq_en;
    assign irq       = r_irq;
`else
    assign w_irq_bit = 1'b0;
`endif

    // Only the word index selects a register; the rest of the address is ignored.
    assign w_unused_ok = &{1'b0, wb_adr_i[23:5], wb_adr_i[1:0]};

    assign wb_ack_o   = r_ack;
    assign wb_error_o = r_err;
    assign wb_stall_o = r_stall;
    assign wb_data_o  = r_data_o;
    assign jtag_tck   = r_tck;
    assign jtag_tms   = r_tms_o;
    assign jtag_tdi   = r_tdi_o;

    // Bus decode, error classification and read mux.
    always_comb begin
        w_req    = wb_cyc_i & wb_stb_i & ~r_stall;
        w_reg    = wb_adr_i[4:2];
        w_busy   = (r_state != S_IDLE);
        w_cnt_ok = (wb_data_i[5:0] != 6'd0) && (wb_data_i[5:0] <= 6'd32);
        w_err    = (w_reg > A_TDO) ||
                   (wb_we_i && (w_busy || (w_reg == A_TDO) ||
                                ((w_reg == A_CTRL) && !w_cnt_ok)));
        w_wr_ok  = w_req & wb_we_i & ~w_err;
        w_start  = w_wr_ok && (w_reg == A_CTRL);
        w_mask   = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                    {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
        w_div_wr = (32'(r_divider) & ~w_mask) | (wb_data_i & w_mask);
        w_tms_wr = (r_tms & ~w_mask) | (wb_data_i & w_mask);
        w_tdi_wr = (r_tdi & ~w_mask) | (wb_data_i & w_mask);
        w_rdata  = '0;
        unique case (w_reg)
            A_CTRL:  w_rdata = {w_busy, w_irq_bit, 24'b0, r_count};
            A_DIV:   w_rdata = 32'(r_divider);
            A_TMS:   w_rdata = r_tms;
            A_TDI:   w_rdata = r_tdi;
            A_TDO:   w_rdata = r_tdo;
            default: w_rdata = '0;
        endcase
    end

    // Shift sequencer next state.
    always_comb begin
        w_next_state = r_state;
        w_phase_done = (r_phase_cnt == r_divider);
        w_last_bit   = (r_bit_idx == (r_count - 6'd1));
        w_next_idx   = r_bit_idx + 6'd1;
        unique case (r_state)
            S_IDLE: if (w_start) w_next_state = S_LOW;
            S_LOW:  if (w_phase_done) w_next_state = S_HIGH;
            S_HIGH: begin
                if (w_phase_done)
                    w_next_state = w_last_bit ? S_IDLE : S_LOW;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_divider   <= '0;
            r_phase_cnt <= '0;
            r_count     <= '0;
            r_bit_idx   <= '0;
            r_tms       <= '0;
            r_tdi       <= '0;
            r_tdo       <= '0;
            r_tck       <= 1'b0;
            r_tms_o     <= 1'b0;
            r_tdi_o     <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_stall     <= 1'b0;
            r_data_o    <= '0;
`ifdef JTAG_MASTER_IRQ_EN
            r_irq_en    <= 1'b0;
            r_irq       <= 1'b0;
`endif
        end else begin
            // One outstanding access: stall covers the response cycle.
            r_stall <= w_req;
            r_ack   <= w_req & ~w_err;
            r_err   <= w_req & w_err;
            if (w_req)
                r_data_o <= (wb_we_i | w_err) ? 32'h0 : w_rdata;

            if (w_wr_ok) begin
                unique case (w_reg)
                    A_CTRL: begin
                        r_count <= wb_data_i[5:0];
`ifdef JTAG_MASTER_IRQ_EN
                        r_irq_en <= wb_data_i[30];
`endif
                    end
                    A_DIV:   r_divider <= w_div_wr[DIVIDER_WIDTH-1:0];
                    A_TMS:   r_tms <= w_tms_wr;
                    A_TDI:   r_tdi <= w_tdi_wr;
                    default: ;
                endcase
            end

            // TCK is a registered copy of the phase so the pin never glitches.
            r_tck <= (w_next_state == S_HIGH);

            if (w_next_state != r_state)
                r_phase_cnt <= '0;
            else if (r_state != S_IDLE)
                r_phase_cnt <= r_phase_cnt + DIVIDER_WIDTH'(1);

            if (w_start) begin
                r_bit_idx <= '0;
                r_tdo     <= '0;
                r_tms_o   <= r_tms[0];
                r_tdi_o   <= r_tdi[0];
            end else if ((r_state == S_LOW) && w_phase_done) begin
                r_tdo[r_bit_idx[4:0]] <= jtag_tdo;
            end else if ((r_state == S_HIGH) && w_phase_done && !w_last_bit) begin
                r_bit_idx <= w_next_idx;
                r_tms_o   <= r_tms[w_next_idx[4:0]];
                r_tdi_o   <= r_tdi[w_next_idx[4:0]];
            end

`ifdef JTAG_MASTER_IRQ_EN
            if (w_start)
                r_irq <= 1'b0;
            else if ((r_state == S_HIGH) && (w_next_state == S_IDLE) && r_irq_en)
                r_irq <= 1'b1;
`endif
        end
    end

endmodule
